spart_tx_sched: RTL and testbench

Sequencer and arbiter for the SPART transmit path. After reset it programs the baud-rate generator divisor over the shared `ioaddr`/`databus` port. It then shares the single `tx_spart` transmitter among `NREQ` byte requesters using round-robin arbitration, issuing one-cycle write strobes only when `tbr` reports the transmit buffer ready. It is the sole master of the SPART I/O port and replaces hand-driven bus stimulus.

---
 rtl/spart_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/spart_tx_sched.sv | 154 +++++++++++++++
 tb/tb_spart_tx_sched.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared constants and FSM encoding for the SPART transmit scheduler.
package spart_pkg;

   localparam logic [1:0] ADDR_TX  = 2'b00;
   localparam logic [1:0] ADDR_DBL = 2'b10;
   localparam logic [1:0] ADDR_DBH = 2'b11;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      SEND,
      WAIT_ACK
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request after the pointer wins.
module rr_arbiter #(
   parameter  int NREQ = 2,
   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IW-1:0]   win_idx
);

   always_comb begin
      logic          found;
      logic [IW-1:0] cidx;
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      cidx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cidx = IW'((int'(ptr) + k) % NREQ);
         if (!found && req[cidx]) begin
            found         = 1'b1;
            win_oh[cidx]  = 1'b1;
            win_idx       = cidx;
         end
      end
   end

endmodule

// File: rtl/spart_tx_sched.sv
// SPART I/O master: programs the baud divisor, then round-robins byte requesters onto the transmitter.
module spart_tx_sched
   import spart_pkg::*;
#(
   parameter int          NREQ        = 2,
   parameter logic [15:0] DIV_RESET   = 16'h0005,
   parameter int          ACK_TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   gnt,
   input  logic [15:0]       cfg_div,
   input  logic              cfg_load,
   input  logic              tbr,
   output logic              iorw,
   output logic [1:0]        ioaddr,
   output logic [7:0]        databus,
   output logic              busy,
   output logic              err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   state_e          state_q, state_d;
   logic            boot_q;
   logic [15:0]     div_q, div_d;
   logic            pend_q, pend_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            iorw_q, iorw_d;
   logic [1:0]      ioaddr_q, ioaddr_d;
   logic [7:0]      databus_q, databus_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic [NREQ-1:0] win_oh;
   logic [IW-1:0]   win_idx;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req),
      .ptr     (ptr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   // A load in the same cycle as the IDLE decision is honoured immediately.
   assign div_d = cfg_load ? cfg_div : div_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q | cfg_load;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (boot_q) begin
         state_d = CFG_LO;
      end else begin
         case (state_q)
            CFG_LO: state_d = CFG_HI;
            CFG_HI: state_d = IDLE;
            IDLE: begin
               if (pend_q || cfg_load) begin
                  pend_d  = 1'b0;
                  state_d = CFG_LO;
               end else if (tbr && (|req)) begin
                  ptr_d   = win_idx;
                  state_d = SEND;
               end
            end
            SEND: begin
               cnt_d   = '0;
               state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!tbr) begin
                  state_d = IDLE;
               end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = CFG_LO;
         endcase
      end
   end

   // Outputs are decoded from the state being entered so they appear registered.
   always_comb begin
      iorw_d    = 1'b1;
      ioaddr_d  = ADDR_TX;
      databus_d = databus_q;
      gnt_d     = '0;
      busy_d    = (state_d != IDLE);
      case (state_d)
         CFG_LO: begin
            ioaddr_d  = ADDR_DBL;
            databus_d = boot_q ? div_q[7:0] : div_d[7:0];
         end
         CFG_HI: begin
            ioaddr_d  = ADDR_DBH;
            databus_d = div_q[15:8];
         end
         SEND: begin
            iorw_d    = 1'b0;
            databus_d = req_data[8*win_idx +: 8];
            gnt_d     = win_oh;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CFG_LO;
         boot_q    <= 1'b1;
         div_q     <= DIV_RESET;
         pend_q    <= 1'b0;
         ptr_q     <= IW'(NREQ - 1);
         cnt_q     <= '0;
         err_q     <= 1'b0;
         iorw_q    <= 1'b1;
         ioaddr_q  <= ADDR_TX;
         databus_q <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         boot_q    <= 1'b0;
         div_q     <= div_d;
         pend_q    <= pend_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         iorw_q    <= iorw_d;
         ioaddr_q  <= ioaddr_d;
         databus_q <= databus_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
      end
   end

   assign gnt     = gnt_q;
   assign iorw    = iorw_q;
   assign ioaddr  = ioaddr_q;
   assign databus = databus_q;
   assign busy    = busy_q;
   assign err     = err_q;

endmodule

// File: tb/tb_spart_tx_sched.sv
// Bench for spart_tx_sched: directed bring-up scenarios followed by randomized traffic against a reference model.
module tb_spart_tx_sched;

   localparam int NREQ = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   gnt;
   logic [15:0]       cfg_div;
   logic              cfg_load;
   logic              tbr;
   logic              iorw;
   logic [1:0]        ioaddr;
   logic [7:0]        databus;
   logic              busy;
   logic              err;

   int n_chk  = 0;
   int n_pass = 0;

   spart_tx_sched #(.NREQ(NREQ), .DIV_RESET(16'h0005), .ACK_TIMEOUT(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .cfg_div  (cfg_div),
      .cfg_load (cfg_load),
      .tbr      (tbr),
      .iorw     (iorw),
      .ioaddr   (ioaddr),
      .databus  (databus),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   task automatic check_reset_vals(input string tag);
      check({tag, "_iorw"}, iorw, 1);
      check({tag, "_addr"}, ioaddr, 0);
      check({tag, "_data"}, databus, 0);
      check({tag, "_gnt"}, gnt, 0);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_err"}, err, 0);
   endtask

   // Three observed cycles: low divisor byte, high divisor byte, back to idle.
   task automatic expect_cfg(input string tag, input logic [15:0] div);
      tick();
      check({tag, "_lo_addr"}, ioaddr, 2'b10);
      check({tag, "_lo_data"}, databus, div[7:0]);
      check({tag, "_lo_iorw"}, iorw, 1);
      tick();
      check({tag, "_hi_addr"}, ioaddr, 2'b11);
      check({tag, "_hi_data"}, databus, div[15:8]);
      tick();
      check({tag, "_idle_addr"}, ioaddr, 2'b00);
      check({tag, "_idle_iorw"}, iorw, 1);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   task automatic wait_strobe(input string tag, input logic [NREQ-1:0] eg, input logic [7:0] ed);
      int n;
      bit found;
      n = 0;
      found = 0;
      while (!found && n < 20) begin
         tick();
         n++;
         if (!iorw) found = 1;
      end
      check({tag, "_found"}, found, 1);
      check({tag, "_lat"}, n, 1);
      check({tag, "_gnt"}, gnt, eg);
      check({tag, "_data"}, databus, ed);
   endtask

   task automatic ack(input string tag);
      tbr = 0;
      tick();
      check({tag, "_wait_busy"}, busy, 1);
      check({tag, "_wait_gnt"}, gnt, 0);
      tick();
      check({tag, "_idle_busy"}, busy, 0);
      tbr = 1;
   endtask

   initial begin
      int n;
      int last_win;
      int gap;
      int fall_cnt;
      int frame_cnt;
      int n_gr;
      int w;
      bit cfg_owed;
      logic [15:0] exp_div;

      rst = 0; req = '0; req_data = '0; cfg_div = '0; cfg_load = 0; tbr = 1;
      repeat (3) tick();
      check_reset_vals("rst");
      rst = 1;
      expect_cfg("boot", 16'h0005);

      // Two requesters alternate, requester 0 first out of reset.
      req_data = 24'h005AF3;
      req = 3'b011;
      for (int k = 0; k < 3; k++) begin
         wait_strobe("alt", (k % 2 == 0) ? 3'b001 : 3'b010, (k % 2 == 0) ? 8'hF3 : 8'h5A);
         ack("alt");
      end

      req = 3'b001;
      req_data[7:0] = 8'h6A;
      wait_strobe("single", 3'b001, 8'h6A);
      req = '0;
      ack("single");

      // Reconfiguration requested while the ack is outstanding and req[1] waits.
      req = 3'b001;
      req_data[7:0] = 8'h11;
      wait_strobe("cfgw", 3'b001, 8'h11);
      req = 3'b010;
      req_data[15:8] = 8'hC4;
      tick();
      cfg_div = 16'h0102; cfg_load = 1; tbr = 0;
      tick();
      check("cfgw_ack_busy", busy, 0);
      check("cfgw_ack_gnt", gnt, 0);
      cfg_load = 0; tbr = 1;
      expect_cfg("cfgw", 16'h0102);
      tick();
      check("cfgw_req1_gnt", gnt, 3'b010);
      check("cfgw_req1_data", databus, 8'hC4);
      check("cfgw_req1_iorw", iorw, 0);
      req = '0;
      ack("cfgw_req1");

      // tbr never falls: timeout after 8 ack cycles, err sticky afterwards.
      req = 3'b001;
      req_data[7:0] = 8'h21;
      wait_strobe("to", 3'b001, 8'h21);
      req = '0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) n++;
         else break;
      end
      check("to_cycles", n, 8);
      check("to_err", err, 1);
      req = 3'b010;
      req_data[15:8] = 8'h77;
      wait_strobe("after_to", 3'b010, 8'h77);
      req = '0;
      ack("after_to");
      check("err_sticky", err, 1);

      // Reset mid-ack with a load pending; the load must be discarded.
      req = 3'b001;
      req_data[7:0] = 8'h3C;
      wait_strobe("midrst", 3'b001, 8'h3C);
      req = '0;
      cfg_div = 16'hABCD; cfg_load = 1;
      tick();
      cfg_load = 0;
      #2 rst = 0;
      #1 check_reset_vals("midrst_async");
      tick();
      tick();
      rst = 1;
      expect_cfg("midrst", 16'h0005);

      // Randomized traffic with a simple transmitter model driving tbr.
      last_win = NREQ - 1; gap = 100; fall_cnt = 0; frame_cnt = 0; n_gr = 0;
      cfg_owed = 0; exp_div = 16'h0005;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         gap++;
         if (ioaddr == 2'b10) check("rnd_div_lo", databus, exp_div[7:0]);
         if (ioaddr == 2'b11) begin
            check("rnd_div_hi", databus, exp_div[15:8]);
            cfg_owed = 0;
         end
         if (!iorw) begin
            w = rr_pick(req, last_win);
            check("rnd_gap", gap >= 3, 1);
            check("rnd_cfg_first", cfg_owed, 0);
            check("rnd_winner_valid", w >= 0, 1);
            if (w >= 0) begin
               check("rnd_gnt", gnt, 1 << w);
               check("rnd_data", databus, req_data[8*w +: 8]);
               last_win = w;
               req[w] = 0;
            end
            gap = 0;
            n_gr++;
            n = $urandom_range(0, 2);
            if (n == 0) begin
               tbr = 0;
               frame_cnt = $urandom_range(2, 8);
            end else begin
               fall_cnt = n;
            end
         end else begin
            check("rnd_gnt_idle", gnt, 0);
            if (fall_cnt > 0) begin
               fall_cnt--;
               if (fall_cnt == 0) begin
                  tbr = 0;
                  frame_cnt = $urandom_range(2, 8);
               end
            end else if (!tbr) begin
               frame_cnt--;
               if (frame_cnt <= 0) tbr = 1;
            end
         end
         cfg_load = 0;
         if (cyc < 2900) begin
            for (int i = 0; i < NREQ; i++)
               if (!req[i] && $urandom_range(0, 3) == 0) begin
                  req[i] = 1;
                  req_data[8*i +: 8] = 8'($urandom);
               end
            if (ioaddr == 2'b00 && $urandom_range(0, 60) == 0) begin
               cfg_div = 16'($urandom);
               exp_div = cfg_div;
               cfg_load = 1;
               cfg_owed = 1;
            end
         end
      end
      check("rnd_cfg_served", cfg_owed, 0);
      check("rnd_err", err, 0);
      check("rnd_grants", n_gr > 100, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
